rv_iopmp_entry_bram_bridge: RTL and testbench

Parametrised bridge between the IOPMP register map's word-wide entry-table port and a single-port entry BRAM whose row is wider than the bus word. It generalises the fixed 128-to-32 converter to any power-of-two width ratio and any BRAM read latency. It adds byte-strobed read-modify-write, strobe-driven fast paths, and an error response for out-of-range rows. It sits between rv_iopmp_regmap and the entry BRAM inside the regmap wrapper.

---
 rtl/rv_iopmp_pkg.sv | 21 ++
 rtl/rv_iopmp_bram_word_merge.sv | 33 +++
 rtl/rv_iopmp_entry_bram_bridge.sv | 175 +++++++++++++++++
 tb/tb_rv_iopmp_entry_bram_bridge.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_iopmp_pkg.sv
// rtl/rv_iopmp_pkg.sv - shared types and width helpers for the IOPMP entry BRAM bridge
package rv_iopmp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    RESP
  } bram_bridge_state_e;

  // Offset bits needed to pick one bus word out of a BRAM row; zero when a row is one word.
  function automatic int bram_off_width(input int bram_dw, input int bus_dw);
    return (bram_dw / bus_dw > 1) ? $clog2(bram_dw / bus_dw) : 0;
  endfunction

  function automatic int bram_row_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rv_iopmp_bram_word_merge.sv
// rtl/rv_iopmp_bram_word_merge.sv - selects one bus word of a row and merges strobed bytes into it
module rv_iopmp_bram_word_merge #(
  parameter int BRAM_DWIDTH = 128,
  parameter int BUS_DWIDTH  = 32,
  parameter int OFF_WS      = 2
) (
  input  logic [BRAM_DWIDTH-1:0]  row_i,
  input  logic [OFF_WS-1:0]       off_i,
  input  logic [BUS_DWIDTH-1:0]   word_i,
  input  logic [BUS_DWIDTH/8-1:0] be_i,
  output logic [BRAM_DWIDTH-1:0]  row_o,
  output logic [BUS_DWIDTH-1:0]   word_o
);

  localparam int WPR  = BRAM_DWIDTH / BUS_DWIDTH;
  localparam int BE_W = BUS_DWIDTH / 8;

  always_comb begin
    row_o  = row_i;
    word_o = '0;
    for (int k = 0; k < WPR; k++) begin
      if (off_i == OFF_WS'(k)) begin
        word_o = row_i[k*BUS_DWIDTH +: BUS_DWIDTH];
        for (int b = 0; b < BE_W; b++) begin
          if (be_i[b]) begin
            row_o[k*BUS_DWIDTH + b*8 +: 8] = word_i[b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/rv_iopmp_entry_bram_bridge.sv
// rtl/rv_iopmp_entry_bram_bridge.sv - bus-word entry port to wide-row single-port BRAM, with byte-strobed RMW
module rv_iopmp_entry_bram_bridge
  import rv_iopmp_pkg::*;
#(
  parameter int BRAM_DWIDTH  = 128,
  parameter int BUS_DWIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int READ_LATENCY = 1,
  localparam int ROW_AW      = bram_row_aw(DEPTH),
  localparam int OFF_W       = bram_off_width(BRAM_DWIDTH, BUS_DWIDTH),
  localparam int ADDR_W      = ROW_AW + OFF_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [BUS_DWIDTH-1:0]   req_wdata_i,
  input  logic [BUS_DWIDTH/8-1:0] req_be_i,
  output logic                    rsp_valid_o,
  output logic [BUS_DWIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    bram_en_o,
  output logic                    bram_we_o,
  output logic [ROW_AW-1:0]       bram_addr_o,
  output logic [BRAM_DWIDTH-1:0]  bram_din_o,
  input  logic [BRAM_DWIDTH-1:0]  bram_dout_i
);

  localparam int WPR    = BRAM_DWIDTH / BUS_DWIDTH;
  localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;
  localparam int CNT_W  = $clog2(READ_LATENCY + 1);
  localparam int BE_W   = BUS_DWIDTH / 8;
  localparam bit ONE_WORD_ROW = (WPR == 1);

  bram_bridge_state_e state_q;

  logic                   req_ready_q;
  logic [ROW_AW-1:0]      req_row;
  logic [OFF_WS-1:0]      req_off;
  logic [OFF_WS-1:0]      off_q;
  logic                   wr_q;
  logic [BUS_DWIDTH-1:0]  wdata_q;
  logic [BE_W-1:0]        be_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   bram_en_q;
  logic                   bram_we_q;
  logic [ROW_AW-1:0]      bram_addr_q;
  logic [BRAM_DWIDTH-1:0] bram_din_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic [BUS_DWIDTH-1:0]  rsp_rdata_q;
  logic [BRAM_DWIDTH-1:0] merged_row;
  logic [BUS_DWIDTH-1:0]  sel_word;

  assign req_row = req_addr_i[ADDR_W-1 -: ROW_AW];

  generate
    if (OFF_W > 0) begin : g_off
      assign req_off = req_addr_i[OFF_WS-1:0];
    end else begin : g_no_off
      assign req_off = '0;
    end
  endgenerate

  // The same merge serves read select (strobes ignored) and write merge (row from BRAM).
  rv_iopmp_bram_word_merge #(
    .BRAM_DWIDTH (BRAM_DWIDTH),
    .BUS_DWIDTH  (BUS_DWIDTH),
    .OFF_WS      (OFF_WS)
  ) u_merge (
    .row_i  (bram_dout_i),
    .off_i  (off_q),
    .word_i (wdata_q),
    .be_i   (be_q),
    .row_o  (merged_row),
    .word_o (sel_word)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      off_q       <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      cnt_q       <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            off_q       <= req_off;
            wr_q        <= req_we_i;
            wdata_q     <= req_wdata_i;
            be_q        <= req_be_i;
            if (int'(req_row) >= DEPTH) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (req_we_i && (req_be_i == '0)) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else if (req_we_i && ONE_WORD_ROW && (&req_be_i)) begin
              state_q     <= WR_ISSUE;
              bram_en_q   <= 1'b1;
              bram_we_q   <= 1'b1;
              bram_addr_q <= req_row;
              bram_din_q  <= BRAM_DWIDTH'(req_wdata_i);
            end else begin
              state_q     <= RD_ISSUE;
              bram_en_q   <= 1'b1;
              bram_addr_q <= req_row;
            end
          end
        end
        RD_ISSUE: begin
          bram_en_q <= 1'b0;
          cnt_q     <= CNT_W'(1);
          state_q   <= RD_WAIT;
        end
        RD_WAIT: begin
          // bram_dout_i is valid in the last RD_WAIT cycle
          if (cnt_q == CNT_W'(READ_LATENCY)) begin
            if (wr_q) begin
              bram_din_q <= merged_row;
              bram_en_q  <= 1'b1;
              bram_we_q  <= 1'b1;
              state_q    <= WR_ISSUE;
            end else begin
              rsp_rdata_q <= sel_word;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WR_ISSUE: begin
          bram_en_q   <= 1'b0;
          bram_we_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign bram_en_o   = bram_en_q;
  assign bram_we_o   = bram_we_q;
  assign bram_addr_o = bram_addr_q;
  assign bram_din_o  = bram_din_q;

endmodule

// File: tb/tb_rv_iopmp_entry_bram_bridge.sv
// tb/tb_rv_iopmp_entry_bram_bridge.sv - scoreboard bench for two bridge configurations
module tb_rv_iopmp_entry_bram_bridge;

  typedef struct {
    int          due;
    logic [63:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: 128/32, DEPTH 6, READ_LATENCY 1
  logic         a_valid, a_ready, a_we;
  logic [4:0]   a_addr;
  logic [31:0]  a_wdata, a_rdata;
  logic [3:0]   a_be;
  logic         a_rsp_valid, a_err, a_en, a_bwe;
  logic [2:0]   a_baddr;
  logic [127:0] a_din, a_dout;

  // Instance B: 64/64, DEPTH 8, READ_LATENCY 3
  logic         b_valid, b_ready, b_we;
  logic [2:0]   b_addr, b_baddr;
  logic [63:0]  b_wdata, b_rdata, b_din, b_dout, b_p0, b_p1;
  logic [7:0]   b_be;
  logic         b_rsp_valid, b_err, b_en, b_bwe;

  rv_iopmp_entry_bram_bridge #(.BRAM_DWIDTH(128), .BUS_DWIDTH(32), .DEPTH(6), .READ_LATENCY(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(a_valid), .req_ready_o(a_ready), .req_we_i(a_we),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata), .req_be_i(a_be), .rsp_valid_o(a_rsp_valid),
    .rsp_rdata_o(a_rdata), .rsp_err_o(a_err), .bram_en_o(a_en), .bram_we_o(a_bwe),
    .bram_addr_o(a_baddr), .bram_din_o(a_din), .bram_dout_i(a_dout)
  );

  rv_iopmp_entry_bram_bridge #(.BRAM_DWIDTH(64), .BUS_DWIDTH(64), .DEPTH(8), .READ_LATENCY(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(b_we),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata), .req_be_i(b_be), .rsp_valid_o(b_rsp_valid),
    .rsp_rdata_o(b_rdata), .rsp_err_o(b_err), .bram_en_o(b_en), .bram_we_o(b_bwe),
    .bram_addr_o(b_baddr), .bram_din_o(b_din), .bram_dout_i(b_dout)
  );

  logic [127:0] mem_a [8] = '{
    1: {4{32'h11111111}},
    2: 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000,
    3: 128'h00112233_44556677_8899AABB_CCDDEEFF,
    5: {128{1'b1}},
    default: '0
  };
  logic [63:0] mem_b [8] = '{7: 64'h77776666_55554444, default: '0};
  int rd_cnt_a = 0, wr_cnt_a = 0, rd_cyc_a = 0, wr_cyc_a = 0;
  int rd_cnt_b = 0, wr_cnt_b = 0, rd_cyc_b = 0, wr_cyc_b = 0;

  always @(posedge clk) begin
    if (a_en) begin
      if (a_bwe) begin
        mem_a[a_baddr] <= a_din;
        wr_cnt_a <= wr_cnt_a + 1;
        wr_cyc_a <= cyc;
      end else begin
        a_dout   <= mem_a[a_baddr];
        rd_cnt_a <= rd_cnt_a + 1;
        rd_cyc_a <= cyc;
      end
    end
  end

  always @(posedge clk) begin
    b_p1   <= b_p0;
    b_dout <= b_p1;
    if (b_en) begin
      if (b_bwe) begin
        mem_b[b_baddr] <= b_din;
        wr_cnt_b <= wr_cnt_b + 1;
        wr_cyc_b <= cyc;
      end else begin
        b_p0     <= mem_b[b_baddr];
        rd_cnt_b <= rd_cnt_b + 1;
        rd_cyc_b <= cyc;
      end
    end
  end

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && a_rsp_valid) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_rsp: got rsp_valid=1 at cycle %0d, expected none", cyc);
      end else begin
        ea = q_a.pop_front();
        chk({ea.name, "_rsp_cycle"}, 128'(cyc), 128'(ea.due));
        chk({ea.name, "_rdata"}, 128'(a_rdata), 128'(ea.rdata));
        chk({ea.name, "_err"}, 128'(a_err), 128'(ea.err));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_rsp_valid) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_rsp: got rsp_valid=1 at cycle %0d, expected none", cyc);
      end else begin
        eb = q_b.pop_front();
        chk({eb.name, "_rsp_cycle"}, 128'(cyc), 128'(eb.due));
        chk({eb.name, "_rdata"}, 128'(b_rdata), 128'(eb.rdata));
        chk({eb.name, "_err"}, 128'(b_err), 128'(eb.err));
      end
    end
  end

  task automatic issue_a(input logic we, input logic [4:0] addr, input logic [31:0] wd, input logic [3:0] be,
                         input bit push, input int lat, input logic [31:0] rd, input logic err,
                         input string name, output int acc);
    int n = 0;
    while (!a_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got ready=0 after %0d cycles, expected ready=1", name, n);
    end
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
    acc = cyc;
    if (push) q_a.push_back('{acc + lat, 64'(rd), err, name});
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_we = 1'($urandom); a_addr = 5'($urandom); a_wdata = $urandom; a_be = 4'($urandom);
  endtask

  task automatic issue_b(input logic we, input logic [2:0] addr, input logic [63:0] wd, input logic [7:0] be,
                         input int lat, input logic [63:0] rd, input string name, output int acc);
    int n = 0;
    while (!b_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!b_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got ready=0 after %0d cycles, expected ready=1", name, n);
    end
    b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
    acc = cyc;
    q_b.push_back('{acc + lat, rd, 1'b0, name});
    @(posedge clk);
    #1;
    b_valid = 1'b0; b_we = 1'($urandom); b_addr = 3'($urandom); b_wdata = {$urandom, $urandom}; b_be = 8'($urandom);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_rsp_timeout: got %0d pending responses, expected 0", name, q_a.size() + q_b.size());
      q_a.delete();
      q_b.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int acc, acc2, rd0, wr0;
    logic [127:0] row1_before;
    rst = 1'b1;
    a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    repeat (3) @(negedge clk);
    chk("a_reset_ctrl", {a_ready, a_rsp_valid, a_err, a_en, a_bwe, a_baddr}, '0);
    chk("a_reset_data", {a_rdata, a_din}, '0);
    chk("b_reset_ctrl", {b_ready, b_rsp_valid, b_err, b_en, b_bwe, b_baddr}, '0);
    chk("b_reset_data", {b_rdata, b_din}, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("a_ready_after_reset", 128'(a_ready), 128'd1);
    chk("b_ready_after_reset", 128'(b_ready), 128'd1);
    @(negedge clk);

    // A: read row 3 word 2
    rd0 = rd_cnt_a;
    issue_a(0, {3'd3, 2'd2}, 32'h0, 4'h0, 1, 3, 32'h44556677, 0, "a_read_r3w2", acc);
    drain("a_read_r3w2");
    chk("a_read_en_cycle", 128'(rd_cyc_a - acc), 128'd1);
    chk("a_read_count", 128'(rd_cnt_a - rd0), 128'd1);

    // A: partial write row 5 word 1
    wr0 = wr_cnt_a;
    issue_a(1, {3'd5, 2'd1}, 32'hAABBCCDD, 4'b0101, 1, 4, 32'h44556677, 0, "a_pwrite_r5w1", acc);
    drain("a_pwrite_r5w1");
    chk("a_pwrite_row5", mem_a[5], 128'hFFFFFFFF_FFFFFFFF_FFBBFFDD_FFFFFFFF);
    chk("a_pwrite_rd_en_cycle", 128'(rd_cyc_a - acc), 128'd1);
    chk("a_pwrite_wr_en_cycle", 128'(wr_cyc_a - acc), 128'd3);
    chk("a_pwrite_wr_count", 128'(wr_cnt_a - wr0), 128'd1);

    issue_a(0, {3'd5, 2'd1}, 32'h0, 4'h0, 1, 3, 32'hFFBBFFDD, 0, "a_read_r5w1", acc);
    drain("a_read_r5w1");

    // A: out-of-range rows 7 and 6 (DEPTH boundary)
    rd0 = rd_cnt_a;
    wr0 = wr_cnt_a;
    issue_a(0, {3'd7, 2'd0}, 32'h0, 4'h0, 1, 1, 32'hFFBBFFDD, 1, "a_err_row7", acc);
    drain("a_err_row7");
    issue_a(1, {3'd6, 2'd3}, 32'h12121212, 4'hF, 1, 1, 32'hFFBBFFDD, 1, "a_err_row6", acc);
    drain("a_err_row6");
    chk("a_err_no_bram", 128'({rd_cnt_a - rd0, wr_cnt_a - wr0}), 128'd0);

    // A: zero-strobe write immediately followed by a read
    wr0 = wr_cnt_a;
    issue_a(1, {3'd2, 2'd0}, 32'hCAFEF00D, 4'h0, 1, 1, 32'hFFBBFFDD, 0, "a_zwrite_r2", acc);
    issue_a(0, {3'd2, 2'd0}, 32'h0, 4'h0, 1, 3, 32'hDEAD0000, 0, "a_read_r2w0", acc2);
    drain("a_b2b");
    chk("a_b2b_accept_gap", 128'(acc2 - acc), 128'd2);
    chk("a_zwrite_no_write", 128'(wr_cnt_a - wr0), 128'd0);

    // A: all strobes with several words per row still goes through read-modify-write
    issue_a(1, {3'd0, 2'd3}, 32'h12345678, 4'hF, 1, 4, 32'hDEAD0000, 0, "a_fwrite_r0w3", acc);
    drain("a_fwrite_r0w3");
    chk("a_fwrite_row0", mem_a[0], {32'h12345678, 96'h0});

    // B: one-word rows, READ_LATENCY 3
    rd0 = rd_cnt_b;
    issue_b(1, 3'd4, 64'h01020304_05060708, 8'hFF, 2, 64'h0, "b_fwrite_r4", acc);
    drain("b_fwrite_r4");
    chk("b_fwrite_wr_en_cycle", 128'(wr_cyc_b - acc), 128'd1);
    chk("b_fwrite_no_read", 128'(rd_cnt_b - rd0), 128'd0);
    chk("b_fwrite_row4", 128'(mem_b[4]), 128'h01020304_05060708);
    issue_b(0, 3'd4, 64'h0, 8'h0, 5, 64'h01020304_05060708, "b_read_r4", acc);
    drain("b_read_r4");
    chk("b_read_en_cycle", 128'(rd_cyc_b - acc), 128'd1);
    issue_b(1, 3'd4, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 6, 64'h01020304_05060708, "b_pwrite_r4", acc);
    drain("b_pwrite_r4");
    chk("b_pwrite_wr_en_cycle", 128'(wr_cyc_b - acc), 128'd5);
    chk("b_pwrite_row4", 128'(mem_b[4]), 128'h01020304_BBBBBBBB);
    issue_b(0, 3'd7, 64'h0, 8'h0, 5, 64'h77776666_55554444, "b_read_r7", acc);
    drain("b_read_r7");

    // A: reset during RD_WAIT of a partial write
    wr0 = wr_cnt_a;
    row1_before = mem_a[1];
    issue_a(1, {3'd1, 2'd0}, 32'h55555555, 4'b0011, 0, 0, 32'h0, 0, "a_rst_pwrite", acc);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("a_rst_outputs", {a_en, a_bwe, a_ready, a_rsp_valid}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("a_rst_ready_after", 128'(a_ready), 128'd1);
    repeat (6) @(negedge clk);
    chk("a_rst_no_write", 128'(wr_cnt_a - wr0), 128'd0);
    chk("a_rst_row1", mem_a[1], row1_before);

    issue_a(0, {3'd0, 2'd3}, 32'h0, 4'h0, 1, 3, 32'h12345678, 0, "a_read_after_rst", acc);
    drain("a_read_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
